// File: rtl/bocks_pkg.sv
// Shared types and constants for the bocks ioctl upload path.
package bocks_pkg;

    localparam int unsigned IOCTL_AW    = 25;
    localparam logic [7:0]  UPLOAD_FILL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } upload_state_e;

endpackage

// File: rtl/bocks_upload_timer.sv
// Load/count/expire interval counter; load starts at 1 so expiry lands on the TIMEOUT-th counted cycle.
module bocks_upload_timer #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    localparam logic [W-1:0] FIRST = W'(1);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= FIRST;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/bocks_ioctl_upload.sv
// HPS->core upload responder: serves ioctl_rd byte reads from core memory over a req/ack port.
// Optional BOCKS_UPLOAD_CKSUM_EN enables the running byte checksum on upload_cksum.
module bocks_ioctl_upload
    import bocks_pkg::*;
#(
    parameter int unsigned MEM_AW       = 16,
    parameter logic [7:0]  UPLOAD_INDEX = 8'h01,
    parameter logic [7:0]  FILL         = UPLOAD_FILL,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_upload,
    input  logic                ioctl_rd,
    input  logic [IOCTL_AW-1:0] ioctl_addr,
    input  logic [7:0]          ioctl_index,
    output logic [7:0]          ioctl_din,
    output logic                ioctl_wait,
    output logic                mem_req,
    output logic [MEM_AW-1:0]   mem_addr,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack,
    output logic                upload_err,
    output logic [IOCTL_AW-1:0] upload_count,
    output logic [15:0]         upload_cksum
);

    upload_state_e       state_q, state_d;
    logic [7:0]          din_q, din_d;
    logic                wait_q, wait_d;
    logic                req_q, req_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                hold_q, hold_d;
    logic                abort_q, abort_d;
    logic                upload_q;
    logic [IOCTL_AW-1:0] count_q;

    logic served, aborting, session_start, commit;
    logic tmr_load, tmr_en, tmr_expired;

    assign served        = (ioctl_index == UPLOAD_INDEX) && ((ioctl_addr >> MEM_AW) == '0);
    assign aborting      = abort_q | ~ioctl_upload;
    assign session_start = ioctl_upload & ~upload_q;

    bocks_upload_timer #(
        .W       (8),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            din_q    <= FILL;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
            abort_q  <= 1'b0;
            upload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            abort_q  <= abort_d;
            upload_q <= ioctl_upload;
        end
    end

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        wait_d   = wait_q;
        req_d    = req_q;
        addr_d   = addr_q;
        err_d    = err_q;
        hold_d   = hold_q;
        abort_d  = abort_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        commit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (ioctl_rd && ioctl_upload) begin
                    wait_d = 1'b1;
                    addr_d = ioctl_addr[MEM_AW-1:0];
                    if (served) begin
                        state_d  = FETCH;
                        req_d    = 1'b1;
                        tmr_load = 1'b1;
                        abort_d  = 1'b0;
                    end else begin
                        // FILL answers spend one extra cycle in DONE so wait spans two cycles
                        state_d = DONE;
                        din_d   = FILL;
                        hold_d  = 1'b1;
                    end
                end
            end
            FETCH: begin
                tmr_en = 1'b1;
                if (!ioctl_upload) abort_d = 1'b1;
                if (mem_ack || tmr_expired) begin
                    req_d = 1'b0;
                    if (!mem_ack) err_d = 1'b1;
                    if (aborting) begin
                        state_d = IDLE;
                        wait_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        din_d   = mem_ack ? mem_rdata : FILL;
                    end
                end
            end
            DONE: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    wait_d  = 1'b0;
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ioctl_rd && state_q != IDLE) err_d = 1'b1;
        if (session_start) err_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (session_start) begin
            count_q <= '0;
        end else if (commit) begin
            count_q <= count_q + 1'b1;
        end
    end

`ifdef BOCKS_UPLOAD_CKSUM_EN
    logic [15:0] cksum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cksum_q <= '0;
        end else if (session_start) begin
            cksum_q <= '0;
        end else if (commit) begin
            cksum_q <= cksum_q + {8'h00, din_q};
        end
    end

    assign upload_cksum = cksum_q;
`else
    assign upload_cksum = '0;
`endif

    assign ioctl_din    = din_q;
    assign ioctl_wait   = wait_q;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign upload_err   = err_q;
    assign upload_count = count_q;

endmodule
